// File: rtl/oc7in_ctrl_if.sv
// Bundle of the frame-control and data handshake signals for oc7in_ctrl.
// The thresh/over pair exists only when OC7IN_CTRL_THRESH_EN is defined.
interface oc7in_ctrl_if;
  logic       start;
  logic       abort;
  logic [6:0] din;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [7:0] total;
  logic [2:0] max_word;
`ifdef OC7IN_CTRL_THRESH_EN
  logic [7:0] thresh;
  logic       over;
`endif

  modport master (
    output start, abort, din, in_valid,
`ifdef OC7IN_CTRL_THRESH_EN
    output thresh,
    input  over,
`endif
    input  in_ready, busy, done, total, max_word
  );

  modport slave (
    input  start, abort, din, in_valid,
`ifdef OC7IN_CTRL_THRESH_EN
    input  thresh,
    output over,
`endif
    output in_ready, busy, done, total, max_word
  );
endinterface

// File: rtl/oc7in_ctrl.sv
// Counts ones over a frame of FRAME_LEN 7-bit words: running total and largest per-word count.
// Define OC7IN_CTRL_THRESH_EN to add the thresh input and over output.
module oc7in_ctrl #(
  parameter int FRAME_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  oc7in_ctrl_if.slave bus,
  output logic [1:0]  o_state
);
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_total;
  logic [2:0]    r_max;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_done;
  logic [2:0]    w_pop;
  logic [7:0]    w_total_next;
  logic [2:0]    w_max_next;
  logic          w_last;
`ifdef OC7IN_CTRL_THRESH_EN
  logic [7:0]    r_thresh;
  logic          r_over;
`endif

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 7; i++) begin
      w_pop = w_pop + {2'b00, bus.din[i]};
    end
  end

  assign w_total_next = r_total + {5'd0, w_pop};
  assign w_max_next   = (w_pop > r_max) ? w_pop : r_max;
  assign w_last       = (r_cnt == CW'(FRAME_LEN - 1));

  // Handshake: a word transfers on a rising edge with in_valid && in_ready.
  // in_ready is high only in ACCUM; in_valid may drop at any time to stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_total    <= '0;
      r_max      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef OC7IN_CTRL_THRESH_EN
      r_thresh   <= '0;
      r_over     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start && !bus.abort) begin
            r_state    <= ACCUM;
            r_cnt      <= '0;
            r_total    <= '0;
            r_max      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
`ifdef OC7IN_CTRL_THRESH_EN
            r_thresh   <= bus.thresh;
            r_over     <= 1'b0;
`endif
          end
        end
        ACCUM: begin
          // abort beats a simultaneous word, which is dropped
          if (bus.abort) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (bus.in_valid) begin
            r_total <= w_total_next;
            r_max   <= w_max_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
              r_state    <= DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
`ifdef OC7IN_CTRL_THRESH_EN
              r_over     <= (w_total_next > r_thresh);
`endif
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.total    = r_total;
  assign bus.max_word = r_max;
  assign o_state      = r_state;
`ifdef OC7IN_CTRL_THRESH_EN
  assign bus.over     = r_over;
`endif
endmodule

// File: tb/tb_oc7in_ctrl.sv
// Bench for oc7in_ctrl: frame-level reference model checked every cycle, plus directed literal cases.
// Covers the thresh/over feature when OC7IN_CTRL_THRESH_EN is defined.
module tb_oc7in_ctrl;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oc7in_ctrl_if bus ();
  oc7in_ctrl_if bus3 ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state3;

  oc7in_ctrl #(.FRAME_LEN(FL)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .o_state(dbg_state));
  oc7in_ctrl #(.FRAME_LEN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave), .o_state(dbg_state3));

  int n_checks = 0;
  int n_err = 0;
  int done3_cnt = 0;
  logic [7:0] drv_thresh = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame = list of accepted words ----------------
  logic [6:0] m_words[$];
  bit m_in_frame = 1'b0;
  bit m_done = 1'b0;
  logic [7:0] m_thresh = 8'd0;
  bit m_over = 1'b0;

  function automatic int m_total();
    int s = 0;
    foreach (m_words[i]) s += $countones(m_words[i]);
    return s;
  endfunction

  function automatic int m_max();
    int m = 0;
    foreach (m_words[i]) if ($countones(m_words[i]) > m) m = $countones(m_words[i]);
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_words.delete();
      m_in_frame = 1'b0;
      m_done = 1'b0;
      m_over = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_in_frame = 1'b0;
    end else if (!m_in_frame) begin
      if (bus.start && !bus.abort) begin
        m_words.delete();
        m_in_frame = 1'b1;
        m_thresh = drv_thresh;
        m_over = 1'b0;
      end
    end else if (bus.abort) begin
      m_in_frame = 1'b0;
    end else if (bus.in_valid) begin
      m_words.push_back(bus.din);
      if (m_words.size() == FL) begin
        m_done = 1'b1;
        m_over = (m_total() > int'(m_thresh));
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(m_in_frame && !m_done));
    check("busy", 32'(bus.busy), 32'(m_in_frame));
    check("done", 32'(bus.done), 32'(m_done));
    check("total", 32'(bus.total), 32'(m_total()));
    check("max_word", 32'(bus.max_word), 32'(m_max()));
`ifdef OC7IN_CTRL_THRESH_EN
    check("over", 32'(bus.over), 32'(m_over));
`endif
    if (bus3.done === 1'b1) done3_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic step(input bit s, input bit a, input bit v, input logic [6:0] d);
    bus.start = s;
    bus.abort = a;
    bus.in_valid = v;
    bus.din = d;
`ifdef OC7IN_CTRL_THRESH_EN
    bus.thresh = drv_thresh;
`endif
    @(negedge clk);
    #1;
  endtask

  task automatic step3(input bit s, input bit v, input logic [6:0] d);
    bus3.start = s;
    bus3.abort = 1'b0;
    bus3.in_valid = v;
    bus3.din = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.din = '0;
    bus3.start = 0; bus3.abort = 0; bus3.in_valid = 0; bus3.din = '0;
`ifdef OC7IN_CTRL_THRESH_EN
    bus.thresh = '0;
    bus3.thresh = '0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("reset_total", 32'(bus.total), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 7'h00);

    // all-ones words, back to back
    step(1, 0, 0, 7'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 7'h7F);
    check("ones_done", 32'(bus.done), 32'd1);
    check("ones_total", 32'(bus.total), 32'd56);
    check("ones_max", 32'(bus.max_word), 32'd7);
    step(0, 0, 0, 7'h00);
    check("ones_done_clr", 32'(bus.done), 32'd0);
    check("ones_hold", 32'(bus.total), 32'd56);

    // three-word frame with in_valid gaps on the FRAME_LEN=3 instance
    done3_cnt = 0;
    step3(1, 0, 7'h00);
    step3(0, 1, 7'h01);
    step3(0, 0, 7'h00); step3(0, 0, 7'h00);
    step3(0, 1, 7'h03);
    step3(0, 0, 7'h00); step3(0, 0, 7'h00);
    step3(0, 1, 7'h1E);
    check("f3_done", 32'(bus3.done), 32'd1);
    check("f3_total", 32'(bus3.total), 32'd7);
    check("f3_max", 32'(bus3.max_word), 32'd4);
    repeat (3) step3(0, 0, 7'h00);
    check("f3_pulses", 32'(done3_cnt), 32'd1);
    check("f3_hold", 32'(bus3.total), 32'd7);

    // abort after two words, then restart clears
    step(1, 0, 0, 7'h00);
    step(0, 0, 1, 7'h03);
    step(0, 0, 1, 7'h07);
    step(0, 1, 0, 7'h00);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_total", 32'(bus.total), 32'd5);
    check("abort_max", 32'(bus.max_word), 32'd3);
    step(1, 0, 0, 7'h00);
    check("restart_total", 32'(bus.total), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    step(0, 1, 1, 7'h7F);
    check("abort_word_total", 32'(bus.total), 32'd0);

    // start during ACCUM ignored, then abort during DONE ignored
    step(1, 0, 0, 7'h00);
    step(0, 0, 1, 7'h01);
    step(1, 0, 1, 7'h03);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 7'h7F);
    check("st_acc_done", 32'(bus.done), 32'd1);
    check("st_acc_total", 32'(bus.total), 32'd45);
    step(0, 1, 0, 7'h00);
    check("abort_done_idle", 32'(bus.busy), 32'd0);

    // reset in the middle of a frame
    step(1, 0, 0, 7'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 7'h7F);
    rst_n = 1'b0;
    #1;
    check("rst_total", 32'(bus.total), 32'd0);
    check("rst_max", 32'(bus.max_word), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1;
    bus.start = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_start", 32'(bus.busy), 32'd1);
    step(0, 1, 0, 7'h00);

`ifdef OC7IN_CTRL_THRESH_EN
    drv_thresh = 8'd10;
    step(1, 0, 0, 7'h00);
    step(0, 0, 1, 7'h7F);
    step(0, 0, 1, 7'h0F);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 7'h00);
    check("th_total11", 32'(bus.total), 32'd11);
    check("th_over1", 32'(bus.over), 32'd1);
    step(0, 0, 0, 7'h00);
    check("th_over_hold", 32'(bus.over), 32'd1);
    step(1, 0, 0, 7'h00);
    check("th_over_clr", 32'(bus.over), 32'd0);
    step(0, 0, 1, 7'h7F);
    step(0, 0, 1, 7'h07);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 7'h00);
    check("th_total10", 32'(bus.total), 32'd10);
    check("th_over0", 32'(bus.over), 32'd0);
    step(0, 0, 0, 7'h00);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
      drv_thresh = 8'($urandom_range(0, 60));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 9) < 7, 7'($urandom));
    end
    step(0, 0, 0, 7'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
